// File: rtl/sd_pkg.sv
// Shared definitions for the SD command path: FSM encoding, frame geometry, CRC7 step.
package sd_pkg;

  localparam int unsigned FRAME_BITS   = 48;
  localparam int unsigned CRC_BITS     = 7;
  localparam int unsigned PAYLOAD_BITS = 40;
  localparam int unsigned CNT_W        = $clog2(FRAME_BITS);

  localparam logic [CRC_BITS-1:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_CRC,
    ST_STOP,
    ST_GAP,
    ST_FIN
  } sd_tx_state_e;

  // Start bit, transmission bit, index and argument in frame order, MSB first.
  typedef struct packed {
    logic        start_bit;
    logic        tx_bit;
    logic [5:0]  index;
    logic [31:0] arg;
  } sd_cmd_payload_t;

  // One serial CRC7 update (x^7 + x^3 + 1).
  function automatic logic [CRC_BITS-1:0] crc7_step(input logic [CRC_BITS-1:0] crc,
                                                    input logic                b);
    logic fb;
    fb = crc[CRC_BITS-1] ^ b;
    return {crc[CRC_BITS-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
  endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 with a shift-out mode; the register itself is the output path,
// so the same block can check CRC per bit on the response side.
module crc7_serial
  import sd_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                en,
  input  logic                bit_in,
  input  logic                shift_out,
  output logic [CRC_BITS-1:0] crc
);

  logic [CRC_BITS-1:0] crc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= '0;
    end else if (clear) begin
      crc_q <= '0;
    end else if (shift_out) begin
      crc_q <= {crc_q[CRC_BITS-2:0], 1'b0};
    end else if (en) begin
      crc_q <= crc7_step(crc_q, bit_in);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_transmit.sv
// SD CMD-line transmitter: serializes a 48-bit command frame with on-the-fly CRC7.
// Define SD_TX_NCC_GAP_EN to hold NCC_CYCLES idle cycles between the end bit and done.
module sd_cmd_transmit
  import sd_pkg::*;
#(
  parameter int unsigned NCC_CYCLES = 8
) (
  input  logic        sd_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        sd_cmd_out,
  output logic        sd_cmd_oe,
  output logic        busy,
  output logic        done
);

`ifdef SD_TX_NCC_GAP_EN
  localparam int unsigned GAP_EN = 1;
`else
  localparam int unsigned GAP_EN = 0;
`endif

  localparam int unsigned GAP_CYCLES = NCC_CYCLES * GAP_EN;
  localparam int unsigned GAP_W      = (NCC_CYCLES > 1) ? $clog2(NCC_CYCLES) : 1;
  localparam int unsigned SR_MSB     = PAYLOAD_BITS - 1;

  sd_tx_state_e              state_q;
  logic [PAYLOAD_BITS-1:0]   shreg_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [GAP_W-1:0]          gap_q;
  logic                      out_q;
  logic                      oe_q;
  logic                      busy_q;
  logic                      done_q;

  sd_cmd_payload_t           payload;
  logic [CRC_BITS-1:0]       crc_w;
  logic                      crc_low_unused;
  logic                      crc_clear;
  logic                      crc_en;
  logic                      crc_shift;

  assign payload.start_bit = 1'b0;
  assign payload.tx_bit    = 1'b1;
  assign payload.index     = cmd_index;
  assign payload.arg       = cmd_arg;

  // CRC accumulates exactly the bits being driven during SEND, then shifts itself out.
  assign crc_clear = (state_q == ST_IDLE) && start;
  assign crc_en    = (state_q == ST_SEND);
  assign crc_shift = (state_q == ST_CRC);

  crc7_serial u_crc (
    .clk       (sd_clk),
    .reset     (reset),
    .clear     (crc_clear),
    .en        (crc_en),
    .bit_in    (shreg_q[SR_MSB]),
    .shift_out (crc_shift),
    .crc       (crc_w)
  );

  assign crc_low_unused = ^crc_w[CRC_BITS-2:0];

  always_ff @(posedge sd_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      out_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          out_q  <= 1'b1;
          oe_q   <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            shreg_q <= payload;
            cnt_q   <= '0;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          out_q   <= shreg_q[SR_MSB];
          oe_q    <= 1'b1;
          busy_q  <= 1'b1;
          shreg_q <= {shreg_q[SR_MSB-1:0], 1'b0};
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(PAYLOAD_BITS - 1)) state_q <= ST_CRC;
        end
        ST_CRC: begin
          out_q  <= crc_w[CRC_BITS-1];
          oe_q   <= 1'b1;
          busy_q <= 1'b1;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(PAYLOAD_BITS + CRC_BITS - 1)) state_q <= ST_STOP;
        end
        ST_STOP: begin
          out_q   <= 1'b1;
          oe_q    <= 1'b1;
          busy_q  <= 1'b1;
          gap_q   <= '0;
          state_q <= (GAP_CYCLES != 0) ? ST_GAP : ST_FIN;
        end
        // Line released but block still busy, so the controller waits out Ncc.
        ST_GAP: begin
          out_q  <= 1'b1;
          oe_q   <= 1'b0;
          busy_q <= 1'b1;
          gap_q  <= gap_q + GAP_W'(1);
          if (32'(gap_q) + 32'd1 >= GAP_CYCLES) state_q <= ST_FIN;
        end
        ST_FIN: begin
          out_q   <= 1'b1;
          oe_q    <= 1'b0;
          busy_q  <= 1'b1;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          out_q   <= 1'b1;
          oe_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sd_cmd_out = out_q;
  assign sd_cmd_oe  = oe_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
